// File: rtl/bip_control.sv
// rtl/bip_control.sv - BIP control unit: fetch/decode/memrd/exec sequencer (optional BIP_CYCLE_COUNTER_EN adds CYCLES)
module bip_control #(
  parameter logic [10:0] RESET_PC = 11'd0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [15:0] PM_DATA,
  output logic [10:0] PM_ADDR,
  output logic        PM_RD,
  output logic [10:0] OPERAND,
  output logic        DM_RD,
  output logic        DM_WR,
  output logic [1:0]  SEL_A,
  output logic        SEL_B,
  output logic        WR_ACC,
  output logic        OP,
  output logic        HALTED,
  output logic        BUSY
`ifdef BIP_CYCLE_COUNTER_EN
  ,
  output logic [15:0] CYCLES
`endif
);

  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEMRD  = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [10:0] pc;
  logic [15:0] ir;

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // PC advances only at the end of EXEC (HLT never reaches EXEC, so PC freezes); IR captures in DECODE.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc <= RESET_PC;
      ir <= 16'h0000;
    end else begin
      if (state == S_EXEC) begin
        pc <= pc + 11'd1;
      end
      if (state == S_DECODE) begin
        ir <= PM_DATA;
      end
    end
  end

  assign PM_ADDR = pc;
  assign OPERAND = ir[10:0];
  assign HALTED  = (state == S_HALT);
  assign BUSY    = (state == S_FETCH) || (state == S_DECODE) ||
                   (state == S_MEMRD) || (state == S_EXEC);

  // Next-state and strobe decode; the DECODE branch looks at PM_DATA because IR is only loaded at its end.
  always_comb begin
    state_next = state;
    PM_RD      = 1'b0;
    DM_RD      = 1'b0;
    DM_WR      = 1'b0;
    SEL_A      = 2'b00;
    SEL_B      = 1'b0;
    WR_ACC     = 1'b0;
    OP         = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        PM_RD      = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case (PM_DATA[15:11])
          OPC_LD, OPC_ADD, OPC_SUB: state_next = S_MEMRD;
          OPC_HLT:                  state_next = S_HALT;
          default:                  state_next = S_EXEC;
        endcase
      end
      S_MEMRD: begin
        DM_RD      = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        state_next = S_FETCH;
        case (ir[15:11])
          OPC_STO: begin
            DM_WR = 1'b1;
          end
          OPC_LD: begin
            WR_ACC = 1'b1;
            SEL_A  = 2'b00;
          end
          OPC_LDI: begin
            WR_ACC = 1'b1;
            SEL_A  = 2'b01;
          end
          OPC_ADD: begin
            WR_ACC = 1'b1;
            SEL_A  = 2'b10;
            SEL_B  = 1'b1;
          end
          OPC_ADDI: begin
            WR_ACC = 1'b1;
            SEL_A  = 2'b10;
          end
          OPC_SUB: begin
            WR_ACC = 1'b1;
            SEL_A  = 2'b10;
            SEL_B  = 1'b1;
            OP     = 1'b1;
          end
          OPC_SUBI: begin
            WR_ACC = 1'b1;
            SEL_A  = 2'b10;
            OP     = 1'b1;
          end
          default: begin
          end
        endcase
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

`ifdef BIP_CYCLE_COUNTER_EN
  // Busy-cycle counter; saturates rather than wrapping, and naturally holds in HALT since BUSY is low.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      CYCLES <= 16'h0000;
    end else if (BUSY && (CYCLES != 16'hFFFF)) begin
      CYCLES <= CYCLES + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bip_control.sv
// tb/tb_bip_control.sv - scoreboard bench for bip_control
module tb_bip_control;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [15:0] PM_DATA;
  logic [10:0] PM_ADDR;
  logic        PM_RD;
  logic [10:0] OPERAND;
  logic        DM_RD;
  logic        DM_WR;
  logic [1:0]  SEL_A;
  logic        SEL_B;
  logic        WR_ACC;
  logic        OP;
  logic        HALTED;
  logic        BUSY;
`ifdef BIP_CYCLE_COUNTER_EN
  logic [15:0] CYCLES;
`endif

  logic [15:0] pm [0:2047];
  logic [31:0] exp_q [$];
  logic [31:0] outv;
  int          n_checks;
  int          n_fail;

  bip_control dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START   (START),
    .PM_DATA (PM_DATA),
    .PM_ADDR (PM_ADDR),
    .PM_RD   (PM_RD),
    .OPERAND (OPERAND),
    .DM_RD   (DM_RD),
    .DM_WR   (DM_WR),
    .SEL_A   (SEL_A),
    .SEL_B   (SEL_B),
    .WR_ACC  (WR_ACC),
    .OP      (OP),
    .HALTED  (HALTED),
    .BUSY    (BUSY)
`ifdef BIP_CYCLE_COUNTER_EN
    ,
    .CYCLES  (CYCLES)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Program memory: data valid the cycle after the read strobe.
  always @(posedge CLK) begin
    if (PM_RD) PM_DATA <= pm[PM_ADDR];
  end

  assign outv = {PM_RD, PM_ADDR, DM_RD, DM_WR, OPERAND, WR_ACC, SEL_A, SEL_B, OP, HALTED, BUSY};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] vec(input logic pm_rd, input logic [10:0] pm_addr,
                                      input logic dm_rd, input logic dm_wr,
                                      input logic [10:0] operand, input logic wr_acc,
                                      input logic [1:0] sel_a, input logic sel_b,
                                      input logic op, input logic halted, input logic busy);
    return {pm_rd, pm_addr, dm_rd, dm_wr, operand, wr_acc, sel_a, sel_b, op, halted, busy};
  endfunction

  // Instruction-level reference: walks pm from pc0 and pushes the expected per-cycle outputs.
  task automatic build_expected(input logic [10:0] pc0, input logic [10:0] opnd0,
                                input int max_instr, input int halt_tail);
    logic [10:0] pc_m;
    logic [10:0] opnd;
    logic [15:0] ins;
    logic [4:0]  opc;
    pc_m = pc0;
    opnd = opnd0;
    for (int i = 0; i < max_instr; i++) begin
      ins = pm[pc_m];
      opc = ins[15:11];
      exp_q.push_back(vec(1'b1, pc_m, 1'b0, 1'b0, opnd, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(vec(1'b0, pc_m, 1'b0, 1'b0, opnd, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
      opnd = ins[10:0];
      if (opc == OP_HLT) begin
        for (int k = 0; k < halt_tail; k++)
          exp_q.push_back(vec(1'b0, pc_m, 1'b0, 1'b0, opnd, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        return;
      end
      if (opc == OP_LD || opc == OP_ADD || opc == OP_SUB)
        exp_q.push_back(vec(1'b0, pc_m, 1'b1, 1'b0, opnd, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
      case (opc)
        OP_STO:  exp_q.push_back(vec(1'b0, pc_m, 1'b0, 1'b1, opnd, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
        OP_LD:   exp_q.push_back(vec(1'b0, pc_m, 1'b0, 1'b0, opnd, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
        OP_LDI:  exp_q.push_back(vec(1'b0, pc_m, 1'b0, 1'b0, opnd, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1));
        OP_ADD:  exp_q.push_back(vec(1'b0, pc_m, 1'b0, 1'b0, opnd, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1));
        OP_ADDI: exp_q.push_back(vec(1'b0, pc_m, 1'b0, 1'b0, opnd, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1));
        OP_SUB:  exp_q.push_back(vec(1'b0, pc_m, 1'b0, 1'b0, opnd, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1));
        OP_SUBI: exp_q.push_back(vec(1'b0, pc_m, 1'b0, 1'b0, opnd, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1));
        default: exp_q.push_back(vec(1'b0, pc_m, 1'b0, 1'b0, opnd, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
      endcase
      pc_m = pc_m + 11'd1;
    end
  endtask

  // Pulses START, then pops one expected vector per clock; optional random START while running.
  task automatic run_compare(input string tag, input bit rand_start);
    START = 1'b1;
    while (exp_q.size() > 0) begin
      @(posedge CLK);
      #1;
      START = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
      check(tag, outv, exp_q.pop_front());
    end
    START = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    START = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic clear_pm();
    for (int i = 0; i < 2048; i++) pm[i] = 16'h0000;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RESET    = 1'b1;
    START    = 1'b0;
    PM_DATA  = 16'h0000;
    clear_pm();

    // Reset state, both while held and just after release.
    #12;
    check("reset_async", outv, 32'h0);
    do_reset();
    check("reset_idle", outv, 32'h0);
    repeat (3) @(posedge CLK);
    #1;
    check("idle_hold", outv, 32'h0);

    // LDI 5; ADDI 3; HLT with START pulses in HALT.
    pm[0] = {OP_LDI, 11'd5};
    pm[1] = {OP_ADDI, 11'd3};
    pm[2] = {OP_HLT, 11'd0};
    build_expected(11'd0, 11'd0, 10, 6);
    run_compare("prog_ldi_addi_hlt", 1'b1);
    check("halt_pc", {21'd0, PM_ADDR}, 32'd2);
`ifdef BIP_CYCLE_COUNTER_EN
    check("cycles_hold", {16'd0, CYCLES}, 32'd8);
`endif

    // Memory-reference, store, undefined and immediate mix.
    do_reset();
    clear_pm();
    pm[0] = {OP_LD,   11'h010};
    pm[1] = {OP_STO,  11'h7FF};
    pm[2] = {OP_ADD,  11'h011};
    pm[3] = {OP_SUB,  11'h012};
    pm[4] = {OP_SUBI, 11'h00A};
    pm[5] = {5'b01000, 11'h155};
    pm[6] = {OP_ADDI, 11'h001};
    pm[7] = {OP_HLT,  11'h3C3};
    build_expected(11'd0, 11'd0, 20, 3);
    run_compare("prog_mix", 1'b1);

    // Reset asserted while SUB is in MEMRD.
    do_reset();
    clear_pm();
    pm[0] = {OP_SUB, 11'h020};
    pm[1] = {OP_LDI, 11'h007};
    pm[2] = {OP_HLT, 11'h000};
    exp_q.push_back(vec(1'b1, 11'd0, 1'b0, 1'b0, 11'h000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(vec(1'b0, 11'd0, 1'b0, 1'b0, 11'h000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(vec(1'b0, 11'd0, 1'b1, 1'b0, 11'h020, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    run_compare("sub_to_memrd", 1'b0);
    #2;
    RESET = 1'b1;
    #1;
    check("reset_in_memrd", outv, 32'h0);
    @(posedge CLK);
    #1;
    check("reset_no_exec", outv, 32'h0);
    RESET = 1'b0;
    build_expected(11'd0, 11'd0, 3, 2);
    run_compare("restart_after_reset", 1'b0);

    // Undefined opcodes across the whole address space: PC wraps 2047 -> 0.
    do_reset();
    for (int i = 0; i < 2048; i++) pm[i] = {5'b11111, i[10:0]};
    build_expected(11'd0, 11'd0, 2049, 0);
    run_compare("nop_wrap", 1'b1);
    check("wrap_pc", {21'd0, PM_ADDR}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
